// File: rtl/pkt_stream_pkg.sv
// pkt_stream_pkg: shared definitions for the 512-bit packet beat stream.
//   - beat control codes carried on pkt_ctl
//   - default data/control widths
//   - descriptor type (header beat plus length in beats)
//   - saturating beat-count increment helper
package pkt_stream_pkg;

  localparam int PKT_DATA_W = 512;
  localparam int PKT_CTL_W  = 8;

  localparam int CTL_IDLE   = 0;
  localparam int CTL_SOP    = 1;
  localparam int CTL_MID    = 2;
  localparam int CTL_EOP    = 3;
  localparam int CTL_SINGLE = 4;

  typedef struct packed {
    logic [PKT_DATA_W-1:0] hdr;
    logic [7:0]            beats;
  } desc_t;

  // Beat count add is done 9 bits wide so the carry marks saturation.
  function automatic logic [7:0] beats_inc_sat(input logic [7:0] b);
    logic [8:0] s;
    s = {1'b0, b} + 9'd1;
    return s[8] ? 8'hFF : s[7:0];
  endfunction

endpackage

// File: rtl/pkt_rx_deframer_if.sv
// pkt_rx_deframer_if: beat stream input plus descriptor valid/ready output.
//   pkt_data_in/pkt_ctl_in : incoming beats (no backpressure)
//   hdr_valid/hdr_ready    : descriptor handshake
//   hdr_data/hdr_beats     : descriptor payload (FIFO head)
// Modports: slave = deframer side, master = beat source / descriptor consumer.
interface pkt_rx_deframer_if #(
  parameter int DATA_W = 512,
  parameter int CTL_W  = 8
);
  logic [DATA_W-1:0] pkt_data_in;
  logic [CTL_W-1:0]  pkt_ctl_in;
  logic              hdr_valid;
  logic              hdr_ready;
  logic [DATA_W-1:0] hdr_data;
  logic [7:0]        hdr_beats;

  modport slave (
    input  pkt_data_in, pkt_ctl_in, hdr_ready,
    output hdr_valid, hdr_data, hdr_beats
  );

  modport master (
    output pkt_data_in, pkt_ctl_in, hdr_ready,
    input  hdr_valid, hdr_data, hdr_beats
  );
endinterface

// File: rtl/pkt_rx_deframer_desc_fifo.sv
// desc_fifo: synchronous FIFO with registered full/empty and occupancy.
//   clk, reset : clock, synchronous active-high reset
//   i_push     : write i_wdata (caller only pushes when !o_full or popping)
//   i_pop      : advance head (caller only pops when !o_empty)
//   o_rdata    : current head entry
//   o_full     : no free entry
//   o_empty    : no valid entry
// DEPTH must be a power of two (pointers wrap naturally), minimum 2.
module desc_fifo #(
  parameter int W     = 520,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         i_push,
  input  logic [W-1:0] i_wdata,
  input  logic         i_pop,
  output logic [W-1:0] o_rdata,
  output logic         o_full,
  output logic         o_empty
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  logic          r_full;
  logic          r_empty;

  // Storage is not reset; r_empty gates every use of it.
  always_ff @(posedge clk) begin
    if (i_push) r_mem[r_wr_ptr] <= i_wdata;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_full   <= 1'b0;
      r_empty  <= 1'b1;
    end else begin
      if (i_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (i_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({i_push, i_pop})
        2'b10: begin
          r_count <= r_count + (AW+1)'(1);
          r_full  <= (r_count == (AW+1)'(DEPTH-1));
          r_empty <= 1'b0;
        end
        2'b01: begin
          r_count <= r_count - (AW+1)'(1);
          r_full  <= 1'b0;
          r_empty <= (r_count == (AW+1)'(1));
        end
        default: ;
      endcase
    end
  end

  assign o_rdata = r_mem[r_rd_ptr];
  assign o_full  = r_full;
  assign o_empty = r_empty;

endmodule

// File: rtl/pkt_rx_deframer.sv
// pkt_rx_deframer: checks beat framing, captures the first beat of each
// packet as its header and queues one descriptor {header, beats} per good
// packet. Keeps saturating good / framing-error / drop counters.
//   clk, reset : clock, synchronous active-high reset
//   bus        : beat input and descriptor valid/ready output (slave modport)
//   good_cnt   : descriptors written into the FIFO
//   err_cnt    : framing errors
//   drop_cnt   : good packets lost because the FIFO was full
//
// state  | meaning
// IDLE   | between packets, waiting for SOP or single-beat
// IN_PKT | header captured, counting beats until EOP
module pkt_rx_deframer
  import pkt_stream_pkg::*;
#(
  parameter int DATA_W     = PKT_DATA_W,
  parameter int CTL_W      = PKT_CTL_W,
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             reset,
  pkt_rx_deframer_if.slave bus,
  output logic [CNT_W-1:0] good_cnt,
  output logic [CNT_W-1:0] err_cnt,
  output logic [CNT_W-1:0] drop_cnt
);

  localparam logic [CTL_W-1:0] L_IDLE   = CTL_W'(CTL_IDLE);
  localparam logic [CTL_W-1:0] L_SOP    = CTL_W'(CTL_SOP);
  localparam logic [CTL_W-1:0] L_MID    = CTL_W'(CTL_MID);
  localparam logic [CTL_W-1:0] L_EOP    = CTL_W'(CTL_EOP);
  localparam logic [CTL_W-1:0] L_SINGLE = CTL_W'(CTL_SINGLE);
  localparam int               FW       = DATA_W + 8;

  typedef enum logic {IDLE, IN_PKT} state_t;

  state_t            r_state;
  logic [DATA_W-1:0] r_hdr;
  logic [7:0]        r_beats;
  logic [CNT_W-1:0]  r_good_cnt;
  logic [CNT_W-1:0]  r_err_cnt;
  logic [CNT_W-1:0]  r_drop_cnt;
  logic [DATA_W-1:0] r_last_hdr;
  logic [7:0]        r_last_beats;

  logic              w_push_req;
  logic              w_err;
  logic [DATA_W-1:0] w_push_hdr;
  logic [7:0]        w_push_beats;
  logic              w_push;
  logic              w_pop;
  logic              w_full;
  logic              w_empty;
  logic [FW-1:0]     w_rdata;

  // Descriptor push and framing error decode for this beat.
  always_comb begin
    w_push_req   = 1'b0;
    w_err        = 1'b0;
    w_push_hdr   = bus.pkt_data_in;
    w_push_beats = 8'd1;
    if (r_state == IDLE) begin
      case (bus.pkt_ctl_in)
        L_IDLE, L_SOP: ;
        L_SINGLE:      w_push_req = 1'b1;
        default:       w_err = 1'b1;
      endcase
    end else begin
      case (bus.pkt_ctl_in)
        L_IDLE, L_MID: ;
        L_EOP: begin
          w_push_req   = 1'b1;
          w_push_hdr   = r_hdr;
          w_push_beats = beats_inc_sat(r_beats);
        end
        L_SINGLE: begin
          w_err      = 1'b1;
          w_push_req = 1'b1;
        end
        default: w_err = 1'b1;
      endcase
    end
  end

  assign w_pop  = !w_empty && bus.hdr_ready;
  // Full is judged after this cycle's pop, so a pop frees room for the push.
  assign w_push = w_push_req && (!w_full || w_pop);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= IDLE;
      r_hdr        <= '0;
      r_beats      <= '0;
      r_good_cnt   <= '0;
      r_err_cnt    <= '0;
      r_drop_cnt   <= '0;
      r_last_hdr   <= '0;
      r_last_beats <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.pkt_ctl_in == L_SOP) begin
            r_hdr   <= bus.pkt_data_in;
            r_beats <= 8'd1;
            r_state <= IN_PKT;
          end
        end
        IN_PKT: begin
          case (bus.pkt_ctl_in)
            L_IDLE: ;
            L_MID:  r_beats <= beats_inc_sat(r_beats);
            L_SOP: begin
              r_hdr   <= bus.pkt_data_in;
              r_beats <= 8'd1;
            end
            default: r_state <= IDLE;
          endcase
        end
        default: r_state <= IDLE;
      endcase

      if (w_push && r_good_cnt != '1)
        r_good_cnt <= r_good_cnt + CNT_W'(1);
      if (w_push_req && !w_push && r_drop_cnt != '1)
        r_drop_cnt <= r_drop_cnt + CNT_W'(1);
      if (w_err && r_err_cnt != '1)
        r_err_cnt <= r_err_cnt + CNT_W'(1);

      // Keep the popped entry so the outputs hold once the FIFO drains.
      if (w_pop) begin
        r_last_hdr   <= w_rdata[FW-1:8];
        r_last_beats <= w_rdata[7:0];
      end
    end
  end

  desc_fifo #(
    .W     (FW),
    .DEPTH (FIFO_DEPTH)
  ) u_desc_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_push  (w_push),
    .i_wdata ({w_push_hdr, w_push_beats}),
    .i_pop   (w_pop),
    .o_rdata (w_rdata),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  assign bus.hdr_valid = !w_empty;
  assign bus.hdr_data  = w_empty ? r_last_hdr   : w_rdata[FW-1:8];
  assign bus.hdr_beats = w_empty ? r_last_beats : w_rdata[7:0];

  assign good_cnt = r_good_cnt;
  assign err_cnt  = r_err_cnt;
  assign drop_cnt = r_drop_cnt;

endmodule

// File: doc/pkt_rx_deframer.md
Name: pkt_rx_deframer

Overview:
- Receive-side counterpart of the 512-bit beat stream used by the packet source: consumes pkt_data/pkt_ctl beats, checks framing, and captures the first beat of each packet (L2–L4 headers) as the header word.
- Emits one descriptor per good packet (header word plus length in beats) through a small FIFO with a valid/ready handshake to the parser pipeline.
- Keeps good-packet, framing-error and drop counters for the control plane.

Parameters:
- DATA_W, 512, beat width in bits.
- CTL_W, 8, control code width.
- FIFO_DEPTH, 4, descriptor FIFO entries; power of two, minimum 2.
- CNT_W, 16, width of the statistics counters.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- pkt_data_in  in  DATA_W  beat data.
- pkt_ctl_in  in  CTL_W  beat code: 0 idle, 1 SOP, 2 middle, 3 EOP, 4 single-beat packet, 5..255 illegal.
- hdr_valid  out  1  descriptor available.
- hdr_ready  in  1  consumer accepts a descriptor.
- hdr_data  out  DATA_W  first beat of the packet.
- hdr_beats  out  8  packet length in beats, 1..255, saturating.
- good_cnt  out  CNT_W  descriptors pushed.
- err_cnt  out  CNT_W  framing errors.
- drop_cnt  out  CNT_W  good packets lost because the FIFO was full.

Behaviour:
- Input has no backpressure; every cycle with pkt_ctl_in != 0 is a beat. Idle cycles between beats are legal anywhere, including mid-packet.
- Reset values:
  - State IDLE; FIFO empty.
  - hdr_valid=0; hdr_data=0; hdr_beats=0.
  - All counters 0; header register and beat counter 0.
- FSM, IDLE state:
  - ctl 1: capture pkt_data_in into the header register; beats=1; go to IN_PKT.
  - ctl 4: push descriptor {pkt_data_in, 1}; stay in IDLE.
  - ctl 2 or 3: err_cnt+1; beat discarded; stay in IDLE.
  - ctl >=5: err_cnt+1; stay in IDLE.
  - ctl 0: no action.
- FSM, IN_PKT state:
  - ctl 2: beats+1, saturating at 255.
  - ctl 3: push {header, beats+1 saturated}; go to IDLE.
  - ctl 1: err_cnt+1; current packet abandoned without a push; new header captured; beats=1; stay in IN_PKT.
  - ctl 4: err_cnt+1; current packet abandoned; the single-beat packet is pushed; go to IDLE.
  - ctl >=5: err_cnt+1; packet abandoned; go to IDLE.
  - ctl 0: hold.
- Push:
  - If FIFO not full, write the descriptor and add 1 to good_cnt.
  - If full, add 1 to drop_cnt; the descriptor is lost and FSM progress is unaffected.
- Push when a pop occurs in the same cycle while full: the push succeeds, because full is evaluated after the pop.
- Latency: a descriptor pushed at edge N gives hdr_valid=1 after edge N (visible in cycle N+1) when the FIFO was empty.
- Output handshake:
  - Pop on hdr_valid && hdr_ready.
  - hdr_data and hdr_beats come straight from the FIFO head and stay stable while hdr_valid && !hdr_ready.
  - With hdr_valid=0 the outputs hold their last value (0 after reset).
- Counters saturate at all-ones and never wrap.
- Reset asserted mid-packet discards the partial packet and the FIFO contents, with no counter increments.
- Widths: beats add is 9-bit internally, clamped to 255.

Decomposition:
- Shared package pkt_stream_pkg:
  - ctl code constants CTL_IDLE=0, CTL_SOP=1, CTL_MID=2, CTL_EOP=3, CTL_SINGLE=4.
  - DATA_W/CTL_W defaults.
  - Descriptor struct type {hdr[511:0], beats[7:0]}.
- One sub-module: desc_fifo, a synchronous FIFO with registered count/full/empty, simultaneous push and pop allowed, width DATA_W+8, depth FIFO_DEPTH. The FSM and counters live in the top.

Test Plan:
- Two-beat packet: SOP data A at cycle 2, EOP at cycle 4 (idle between), hdr_ready=1 -> one descriptor with hdr_data=A, hdr_beats=2, good_cnt=1, err_cnt=0.
- Back-to-back single-beat ctl 4 on three consecutive cycles, hdr_ready=0, FIFO_DEPTH=4 -> hdr_valid=1 from the cycle after the first beat; three entries in order; no drops.
- Long packet: SOP, 300 middle beats, EOP -> hdr_beats=255 (saturated), good_cnt=1.
- Framing errors:
  - EOP in IDLE -> err_cnt=1, no descriptor.
  - Then SOP(B), SOP(C), EOP -> err_cnt=2, one descriptor hdr_data=C, hdr_beats=2.
  - Then ctl 7 in IDLE -> err_cnt=3.
- Overflow: hdr_ready=0, six single-beat packets, depth 4 -> good_cnt=4, drop_cnt=2; then hdr_ready=1 drains the first four in order.
- Reset mid-packet: SOP, middle, then reset for 1 cycle, then EOP -> no descriptor, err_cnt=1 (EOP in IDLE), all other counters 0.
